// File: rtl/sd_dat_pkg.sv
// Shared definitions for the card-side SD DAT responder: FSM encoding,
// CRC16 polynomial, status token codes and framing bits.
package sd_dat_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT_START,
    RX_DATA,
    RX_CRC,
    RX_END,
    RX_NCRC,
    TX_STATUS,
    TX_BUSY,
    TX_NAC,
    TX_START,
    TX_DATA,
    TX_CRC,
    TX_END
  } dat_state_t;

  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam logic [2:0]  STATUS_OK      = 3'b010;
  localparam logic [2:0]  STATUS_CRC_ERR = 3'b101;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        END_BIT        = 1'b1;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (init 0), MSB first; clear has priority over enable.
module sd_crc16
  import sd_dat_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic feedback;
  assign feedback = data_bit ^ crc[15];

  always_ff @(posedge sd_clock) begin
    if (reset || clear) begin
      crc <= 16'h0000;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_card_dat_responder.sv
// Card end of a single-line SD DAT link: receives host writes and answers
// with a CRC status token plus busy, and serialises host reads from tx_word.
//
// state         | meaning
// IDLE          | no transfer, DAT released
// RX_WAIT_START | waiting for host start bit
// RX_DATA       | shifting in data bits
// RX_CRC        | shifting in host CRC16
// RX_END        | sampling host end bit
// RX_NCRC       | turnaround before status token
// TX_STATUS     | driving 0,s2,s1,s0,1
// TX_BUSY       | holding DAT low
// TX_NAC        | turnaround before read block
// TX_START      | driving start bit, first word arrives
// TX_DATA       | driving data bits
// TX_CRC        | driving CRC16
// TX_END        | driving end bit
module sd_card_dat_responder
  import sd_dat_pkg::*;
#(
  parameter int BLOCK_WORDS = 1,
  parameter int NAC         = 2,
  parameter int NCRC        = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        dat_in,
  output logic        dat_out,
  output logic        dat_oe,
  input  logic        write_start,
  input  logic        read_start,
  input  logic [3:0]  blocks,
  input  logic        abort,
  output logic [31:0] rx_word,
  output logic        rx_word_valid,
  input  logic [31:0] tx_word,
  output logic        tx_word_req,
  output logic        crc_error,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(BLOCK_WORDS * 32 - 1);
  localparam logic [CNT_W-1:0] NAC_LAST   = CNT_W'(NAC - 1);
  localparam logic [CNT_W-1:0] NCRC_LAST  = CNT_W'(NCRC - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(15);
  localparam logic [CNT_W-1:0] TOKEN_LAST = CNT_W'(4);
  localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(32);

  dat_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sr;
  logic [3:0]       blocks_lat;
  logic [3:0]       blk_cnt;
  logic             status_ok;
  logic             last_blk;
  logic             rx_ok;
  logic             crc_clr;
  logic             crc_en;
  logic             crc_bit;
  logic [15:0]      crc_val;

  assign last_blk = (blk_cnt == blocks_lat - 4'd1);
  assign rx_ok    = (sr[15:0] == crc_val) && (dat_in == END_BIT);
  assign busy     = (state != IDLE);

  // CRC accumulates exactly the data bits on the wire, in both directions.
  always_comb begin
    crc_clr = (state == IDLE) || (state == RX_WAIT_START) || (state == TX_NAC);
    crc_en  = 1'b0;
    crc_bit = 1'b0;
    case (state)
      RX_DATA: begin
        crc_en  = 1'b1;
        crc_bit = dat_in;
      end
      TX_START: begin
        crc_en  = 1'b1;
        crc_bit = tx_word[31];
      end
      TX_DATA: begin
        crc_en  = (cnt != '0);
        crc_bit = (cnt[4:0] == 5'd0) ? tx_word[31] : sr[31];
      end
      default: ;
    endcase
  end

  sd_crc16 u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clr),
    .enable   (crc_en),
    .data_bit (crc_bit),
    .crc      (crc_val)
  );

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sr            <= '0;
      blocks_lat    <= 4'd1;
      blk_cnt       <= '0;
      status_ok     <= 1'b0;
      dat_out       <= 1'b1;
      dat_oe        <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      tx_word_req   <= 1'b0;
      crc_error     <= 1'b0;
      done          <= 1'b0;
    end else begin
      rx_word_valid <= 1'b0;
      tx_word_req   <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        dat_oe  <= 1'b0;
        dat_out <= 1'b1;
        cnt     <= '0;
        blk_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (write_start || read_start) begin
              blocks_lat <= (blocks == 4'd0) ? 4'd1 : blocks;
              blk_cnt    <= '0;
              crc_error  <= 1'b0;
              if (write_start) begin
                state <= RX_WAIT_START;
              end else begin
                state       <= TX_NAC;
                cnt         <= NAC_LAST;
                tx_word_req <= (NAC == 1);
              end
            end
          end
          RX_WAIT_START: begin
            if (dat_in == START_BIT) begin
              state <= RX_DATA;
              cnt   <= DATA_LAST;
            end
          end
          RX_DATA: begin
            sr <= {sr[30:0], dat_in};
            if (cnt[4:0] == 5'd0) begin
              rx_word       <= {sr[30:0], dat_in};
              rx_word_valid <= 1'b1;
            end
            if (cnt == '0) begin
              state <= RX_CRC;
              cnt   <= CRC_LAST;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RX_CRC: begin
            sr <= {sr[30:0], dat_in};
            if (cnt == '0) state <= RX_END;
            else           cnt   <= cnt - 1'b1;
          end
          RX_END: begin
            status_ok <= rx_ok;
            if (!rx_ok) crc_error <= 1'b1;
            state <= RX_NCRC;
            cnt   <= NCRC_LAST;
          end
          RX_NCRC: begin
            if (cnt == '0) begin
              state   <= TX_STATUS;
              dat_oe  <= 1'b1;
              dat_out <= START_BIT;
              sr      <= {(status_ok ? STATUS_OK : STATUS_CRC_ERR), END_BIT, 28'b0};
              cnt     <= TOKEN_LAST;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          TX_STATUS: begin
            if (cnt == '0) begin
              state   <= TX_BUSY;
              dat_out <= 1'b0;
              cnt     <= BUSY_LAST;
            end else begin
              dat_out <= sr[31];
              sr      <= {sr[30:0], 1'b0};
              cnt     <= cnt - 1'b1;
            end
          end
          TX_BUSY: begin
            if (cnt == '0) begin
              dat_oe  <= 1'b0;
              dat_out <= 1'b1;
              if (last_blk) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                blk_cnt <= blk_cnt + 4'd1;
                state   <= RX_WAIT_START;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          TX_NAC: begin
            if (cnt == '0) begin
              state   <= TX_START;
              dat_oe  <= 1'b1;
              dat_out <= START_BIT;
            end else begin
              if (cnt == CNT_W'(1)) tx_word_req <= 1'b1;
              cnt <= cnt - 1'b1;
            end
          end
          TX_START: begin
            dat_out <= tx_word[31];
            sr      <= {tx_word[30:0], 1'b0};
            cnt     <= DATA_LAST;
            state   <= TX_DATA;
          end
          TX_DATA: begin
            if (cnt == '0) begin
              state   <= TX_CRC;
              dat_out <= crc_val[15];
              sr      <= {crc_val[14:0], 17'b0};
              cnt     <= CRC_LAST;
            end else begin
              // Request lands one bit early so the next word loads with no gap.
              if (cnt[4:0] == 5'd0) begin
                dat_out <= tx_word[31];
                sr      <= {tx_word[30:0], 1'b0};
              end else begin
                dat_out <= sr[31];
                sr      <= {sr[30:0], 1'b0};
              end
              tx_word_req <= (cnt[4:0] == 5'd2) && (cnt > WORD_BITS);
              cnt         <= cnt - 1'b1;
            end
          end
          TX_CRC: begin
            if (cnt == '0) begin
              state   <= TX_END;
              dat_out <= END_BIT;
              done    <= last_blk;
            end else begin
              dat_out <= sr[31];
              sr      <= {sr[30:0], 1'b0};
              cnt     <= cnt - 1'b1;
            end
          end
          TX_END: begin
            dat_oe  <= 1'b0;
            dat_out <= 1'b1;
            if (last_blk) begin
              state <= IDLE;
            end else begin
              blk_cnt     <= blk_cnt + 4'd1;
              state       <= TX_NAC;
              cnt         <= NAC_LAST;
              tx_word_req <= (NAC == 1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
